// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type and the request controller state encoding
package cpu_types_pkg;
  localparam int WORD_BITS = 32;
  typedef logic [WORD_BITS-1:0] word_t;
  typedef enum logic [2:0] {FETCH, DECODE, DATA, HALTED, ERROR} reqstate_t;
endpackage

// File: rtl/req_timeout_cnt.sv
// req_timeout_cnt: saturating hit-wait counter; expired flags the last permitted wait cycle
// Ports: CLK clock; nRST async active-low reset; clr restart count; inc count one waiting cycle;
//        expired high while the count equals TIMEOUT-1 (never when TIMEOUT is 0)
module req_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  assign expired = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/request_ctrl.sv
// request_ctrl: multicycle fetch/data request sequencer with halt draining and hit-timeout watchdog
// Ports: CLK, nRST (async active low); ihit/dhit memory hits; halt/mem_read/mem_write decoded controls;
//        iaddr_in/daddr_in/dstore_in datapath values passed through to iaddr/daddr/dmemstore;
//        imemload/dmemload memory returns latched into instr_out/dload_out;
//        iREN/dREN/dWEN request enables; pc_en retire strobe; halted and timeout_err absorbing status
module request_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              halt,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] iaddr_in,
  input  logic [WORD_W-1:0] daddr_in,
  input  logic [WORD_W-1:0] dstore_in,
  input  logic [WORD_W-1:0] imemload,
  input  logic [WORD_W-1:0] dmemload,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] dload_out,
  output logic              pc_en,
  output logic              halted,
  output logic              timeout_err
);
  reqstate_t state, nextState;
  logic iRen, dRen, dWen, retire, expired, cntClr, cntInc;
  always_comb begin
    nextState = state;
    iRen = 1'b0;
    dRen = 1'b0;
    dWen = 1'b0;
    retire = 1'b0;
    case (state)
      FETCH: begin
        iRen = 1'b1;
        nextState = ihit ? DECODE : expired ? ERROR : FETCH;
      end
      DECODE: begin
        nextState = halt ? HALTED : (mem_read | mem_write) ? DATA : FETCH;
        retire = !halt && !(mem_read | mem_write);
      end
      DATA: begin
        // a store wins over a load so the two enables are never high together
        dWen = mem_write;
        dRen = mem_read & ~mem_write;
        nextState = dhit ? FETCH : expired ? ERROR : DATA;
        retire = dhit;
      end
      default: ;
    endcase
  end
  // restart the wait count on every entry into a requesting state
  assign cntClr = (nextState != state) && (nextState == FETCH || nextState == DATA);
  assign cntInc = (state == FETCH && !ihit) || (state == DATA && !dhit);
  req_timeout_cnt #(.TIMEOUT(TIMEOUT)) uTimeout (
    .CLK(CLK),
    .nRST(nRST),
    .clr(cntClr),
    .inc(cntInc),
    .expired(expired)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= FETCH;
      instr_out <= '0;
      dload_out <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH && ihit) instr_out <= imemload;
      if (dRen && dhit) dload_out <= dmemload;
    end
  // reset leaves the state at FETCH, so strobes are gated to drop the moment nRST falls
  assign iREN = nRST & iRen;
  assign dREN = nRST & dRen;
  assign dWEN = nRST & dWen;
  assign pc_en = nRST & retire;
  assign halted = state == HALTED;
  assign timeout_err = state == ERROR;
  assign iaddr = iaddr_in;
  assign daddr = daddr_in;
  assign dmemstore = dstore_in;
endmodule

// File: tb/tb_request_ctrl.sv
// tb_request_ctrl: scoreboard bench for request_ctrl; retired instructions are checked by a monitor
module tb_request_ctrl;
  logic CLK = 1'b0;
  logic nRST, ihit, dhit, halt, mem_read, mem_write;
  logic [31:0] iaddr_in, daddr_in, dstore_in, imemload, dmemload;
  logic iREN, dREN, dWEN, pc_en, halted, timeout_err;
  logic [31:0] iaddr, daddr, dmemstore, instr_out, dload_out;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] dload;
  } retire_t;
  retire_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic pcPrev = 1'b0;

  request_ctrl #(.WORD_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .halt(halt),
    .mem_read(mem_read), .mem_write(mem_write), .iaddr_in(iaddr_in),
    .daddr_in(daddr_in), .dstore_in(dstore_in), .imemload(imemload),
    .dmemload(dmemload), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dmemstore(dmemstore),
    .instr_out(instr_out), .dload_out(dload_out), .pc_en(pc_en),
    .halted(halted), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drives one FETCH hit cycle and leaves the bench in DECODE with inputs settled
  task automatic fetch(input logic [31:0] instr, input logic rd, input logic wr, input logic hl);
    ihit = 1'b1;
    imemload = instr;
    mem_read = rd;
    mem_write = wr;
    halt = hl;
    #1;
    chk("fetch_iREN", 32'(iREN), 32'd1);
    tick();
    ihit = 1'b0;
    #1;
    chk("decode_enables", {29'd0, iREN, dREN, dWEN}, 32'd0);
  endtask

  // the cycle after a pc_en strobe the latches hold the retired instruction's results
  always @(negedge CLK) begin
    if (pcPrev) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL retire_unexpected: got pc_en with instr %h required no retire", instr_out);
      end else begin
        retire_t e;
        e = q.pop_front();
        chk("retire_instr", instr_out, e.instr);
        chk("retire_dload", dload_out, e.dload);
      end
      chk("pc_en_single", 32'(pc_en), 32'd0);
    end
    pcPrev = pc_en;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; halt = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    iaddr_in = 32'h40; daddr_in = 32'h0; dstore_in = 32'h0; imemload = 32'h0; dmemload = 32'h0;
    #2;
    chk("reset_flags", {26'd0, iREN, dREN, dWEN, pc_en, halted, timeout_err}, 32'd0);
    chk("reset_instr", instr_out, 32'd0);
    chk("reset_dload", dload_out, 32'd0);
    tick();
    nRST = 1'b1;
    fetch(32'h00221820, 1'b0, 1'b0, 1'b0);
    q.push_back('{32'h00221820, 32'h0});
    chk("rtype_pc_en", 32'(pc_en), 32'd1);
    chk("iaddr_pass", iaddr, 32'h40);
    tick();
    chk("rtype_iREN_again", 32'(iREN), 32'd1);
    daddr_in = 32'h100;
    fetch(32'h8C220100, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        dhit = 1'b1;
        dmemload = 32'hDEADBEEF;
        q.push_back('{32'h8C220100, 32'hDEADBEEF});
      end
      #1;
      chk("load_dREN", {30'd0, dREN, dWEN}, 32'd2);
      chk("load_daddr", daddr, 32'h100);
      chk("load_no_timeout", 32'(timeout_err), 32'd0);
      if (i < 3) tick();
    end
    tick();
    dhit = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("load_done_enables", {29'd0, iREN, dREN, dWEN}, 32'd4);
    dstore_in = 32'h12345678;
    fetch(32'hAC221000, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        dhit = 1'b1;
        dmemload = 32'hFFFFFFFF;
        q.push_back('{32'hAC221000, 32'hDEADBEEF});
      end
      #1;
      chk("store_enables", {30'd0, dREN, dWEN}, 32'd1);
      chk("store_data", dmemstore, 32'h12345678);
      if (i < 1) tick();
    end
    tick();
    dhit = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        ihit = 1'b1;
        imemload = 32'h00000020;
      end
      #1;
      chk("late_ihit_iREN", 32'(iREN), 32'd1);
      if (i < 3) tick();
    end
    tick();
    ihit = 1'b0;
    q.push_back('{32'h00000020, 32'hDEADBEEF});
    #1;
    chk("late_ihit_no_err", 32'(timeout_err), 32'd0);
    chk("late_ihit_pc_en", 32'(pc_en), 32'd1);
    tick();
    fetch(32'hAC3F0000, 1'b0, 1'b1, 1'b1);
    chk("halt_decode_pc_en", 32'(pc_en), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      ihit = 1'b1;
      dhit = 1'b1;
      #1;
      chk("halted_state", {26'd0, iREN, dREN, dWEN, pc_en, halted, timeout_err}, 32'd2);
      tick();
    end
    ihit = 1'b0; dhit = 1'b0; halt = 1'b0; mem_write = 1'b0;
    nRST = 1'b0;
    #1;
    chk("reset_clears_halt", 32'(halted), 32'd0);
    tick();
    nRST = 1'b1;
    daddr_in = 32'h104;
    fetch(32'h8C230004, 1'b1, 1'b0, 1'b0);
    tick();
    dhit = 1'b1;
    dmemload = 32'hCAFEF00D;
    q.push_back('{32'h8C230004, 32'hCAFEF00D});
    #1;
    chk("load2_dREN", 32'(dREN), 32'd1);
    tick();
    dhit = 1'b0;
    fetch(32'h8C240008, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    dmemload = 32'h11111111;
    #1;
    chk("mid_data_dREN", 32'(dREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("async_drop_dREN", 32'(dREN), 32'd0);
    chk("async_instr", instr_out, 32'd0);
    chk("async_dload", dload_out, 32'd0);
    tick();
    nRST = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("post_reset_iREN", 32'(iREN), 32'd1);
    chk("post_reset_dload", dload_out, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("wait_iREN", 32'(iREN), 32'd1);
      chk("wait_no_err", 32'(timeout_err), 32'd0);
      tick();
    end
    #1;
    chk("timeout_err", {30'd0, iREN, timeout_err}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      ihit = 1'b1;
      tick();
      chk("error_absorbing", {29'd0, iREN, pc_en, timeout_err}, 32'd1);
    end
    ihit = 1'b0;
    tick();
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
